maj_net_eval: RTL and testbench

//   Programmable, sequentially evaluated network of 3-input majority (MAJ3) gates over NUM_IN primary inputs.

---
 rtl/maj_net_eval.sv | 164 ++++++++++++++++
 tb/tb_maj_net_eval.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/maj_net_eval.sv
// rtl/maj_net_eval.sv - run-time programmable MAJ3 gate network, one gate evaluated per clock
// Optional macro MAJ_INV_EN: per-gate operand complement bits stored and applied.
module maj_net_eval #(
  parameter int NUM_IN    = 7,
  parameter int NUM_GATES = 8,
  localparam int IDX_W    = $clog2(1 + NUM_IN + NUM_GATES),
  localparam int AW       = (NUM_GATES > 1) ? $clog2(NUM_GATES) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [AW-1:0]     cfg_addr,
  input  logic [IDX_W-1:0]  cfg_a,
  input  logic [IDX_W-1:0]  cfg_b,
  input  logic [IDX_W-1:0]  cfg_c,
  input  logic [2:0]        cfg_inv,
  input  logic              cfg_out_we,
  input  logic [IDX_W-1:0]  cfg_out,
  output logic              cfg_err,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [NUM_IN-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_data
);

  localparam int NODES = 1 + NUM_IN + NUM_GATES;

  typedef enum logic [1:0] {S_IDLE, S_EVAL, S_DONE} state_t;

  state_t               r_state;
  logic                 r_in_ready;
  logic                 r_out_valid;
  logic                 r_out_data;
  logic                 r_cfg_err;
  logic [NUM_IN-1:0]    r_x;
  logic [NUM_GATES-1:0] r_gv;
  logic [AW-1:0]        r_cnt;
  logic [IDX_W-1:0]     r_sel;
  logic [IDX_W-1:0]     r_ga [NUM_GATES];
  logic [IDX_W-1:0]     r_gb [NUM_GATES];
  logic [IDX_W-1:0]     r_gc [NUM_GATES];

  logic                 w_idle;
  logic                 w_acc;
  logic                 w_addr_ok;
  logic [NODES-1:0]     w_nodes;
  logic [NODES-1:0]     w_nodes_next;
  logic [NUM_GATES-1:0] w_gv_next;
  int                   w_lim;
  logic [2:0]           w_inv;
  logic                 w_opa;
  logic                 w_opb;
  logic                 w_opc;
  logic                 w_maj;
  logic                 w_out_next;

  // Indices at or beyond lim (self, forward or out of range) read as constant 0.
  function automatic logic node_val(input logic [NODES-1:0] nodes,
                                    input logic [IDX_W-1:0] idx, input int lim);
    node_val = 1'b0;
    if (int'(idx) < lim) node_val = nodes[idx];
  endfunction

`ifdef MAJ_INV_EN
  logic [2:0] r_ginv [NUM_GATES];
  assign w_inv = r_ginv[r_cnt];
`else
  logic w_unused_inv;
  assign w_unused_inv = ^cfg_inv;
  assign w_inv        = 3'b000;
`endif

  assign w_idle    = (r_state == S_IDLE);
  assign w_acc     = in_valid && r_in_ready;
  assign w_addr_ok = int'(cfg_addr) < NUM_GATES;

  assign w_nodes = {r_gv, r_x, 1'b0};
  assign w_lim   = 1 + NUM_IN + int'(r_cnt);
  assign w_opa   = node_val(w_nodes, r_ga[r_cnt], w_lim) ^ w_inv[0];
  assign w_opb   = node_val(w_nodes, r_gb[r_cnt], w_lim) ^ w_inv[1];
  assign w_opc   = node_val(w_nodes, r_gc[r_cnt], w_lim) ^ w_inv[2];
  assign w_maj   = (w_opa & w_opb) | (w_opa & w_opc) | (w_opb & w_opc);

  always_comb begin
    w_gv_next        = r_gv;
    w_gv_next[r_cnt] = w_maj;
  end

  // Output value is captured from the post-last-gate node vector so it is registered in DONE.
  assign w_nodes_next = {w_gv_next, r_x, 1'b0};
  assign w_out_next   = node_val(w_nodes_next, r_sel, NODES);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= 1'b0;
      r_cfg_err   <= 1'b0;
      r_x         <= '0;
      r_gv        <= '0;
      r_cnt       <= '0;
      r_sel       <= IDX_W'(NUM_IN + NUM_GATES);
      for (int i = 0; i < NUM_GATES; i++) begin
        r_ga[i] <= '0;
        r_gb[i] <= '0;
        r_gc[i] <= '0;
`ifdef MAJ_INV_EN
        r_ginv[i] <= '0;
`endif
      end
    end else begin
      r_cfg_err <= (cfg_we && (!w_idle || !w_addr_ok)) || (cfg_out_we && !w_idle);
      if (cfg_we && w_idle && w_addr_ok) begin
        r_ga[cfg_addr] <= cfg_a;
        r_gb[cfg_addr] <= cfg_b;
        r_gc[cfg_addr] <= cfg_c;
`ifdef MAJ_INV_EN
        r_ginv[cfg_addr] <= cfg_inv;
`endif
      end
      if (cfg_out_we && w_idle) r_sel <= cfg_out;

      case (r_state)
        S_IDLE: begin
          r_in_ready <= 1'b1;
          if (w_acc) begin
            r_x        <= in_data;
            r_gv       <= '0;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= S_EVAL;
          end
        end
        S_EVAL: begin
          r_gv  <= w_gv_next;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == AW'(NUM_GATES - 1)) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_out_next;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_out_data  <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign cfg_err   = r_cfg_err;

endmodule

// File: tb/tb_maj_net_eval.sv
// tb/tb_maj_net_eval.sv - self-checking bench for maj_net_eval against a node-list reference model
module tb_maj_net_eval;
  localparam int NUM_IN = 7;
  localparam int NUM_GATES = 8;
  localparam int IDX_W = 4;
  localparam int AW = 3;
  localparam int NODES = 1 + NUM_IN + NUM_GATES;
  localparam int LAT = NUM_GATES + 1;

  logic clk, rst_n;
  logic cfg_we, cfg_out_we, cfg_err;
  logic [AW-1:0] cfg_addr;
  logic [IDX_W-1:0] cfg_a, cfg_b, cfg_c, cfg_out;
  logic [2:0] cfg_inv;
  logic in_valid, in_ready, out_valid, out_ready, out_data;
  logic [NUM_IN-1:0] in_data;

  int checks = 0;
  int errors = 0;

  int m_a[NUM_GATES], m_b[NUM_GATES], m_c[NUM_GATES];
  logic [2:0] m_inv[NUM_GATES];
  int m_sel;

  maj_net_eval dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_a(cfg_a),
    .cfg_b(cfg_b), .cfg_c(cfg_c), .cfg_inv(cfg_inv), .cfg_out_we(cfg_out_we),
    .cfg_out(cfg_out), .cfg_err(cfg_err), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: evaluate the node list in index order, counting ones per gate.
  function automatic logic model_eval(input logic [NUM_IN-1:0] x);
    logic vals[NODES];
    int idx, s;
    logic v;
    for (int n = 0; n < NODES; n++) vals[n] = 1'b0;
    for (int i = 0; i < NUM_IN; i++) vals[1 + i] = x[i];
    for (int g = 0; g < NUM_GATES; g++) begin
      s = 0;
      for (int k = 0; k < 3; k++) begin
        idx = (k == 0) ? m_a[g] : (k == 1) ? m_b[g] : m_c[g];
        v = (idx < 1 + NUM_IN + g) ? vals[idx] : 1'b0;
`ifdef MAJ_INV_EN
        if (m_inv[g][k]) v = ~v;
`endif
        s += int'(v);
      end
      vals[1 + NUM_IN + g] = (s >= 2);
    end
    return (m_sel < NODES) ? vals[m_sel] : 1'b0;
  endfunction

  task automatic model_reset();
    for (int g = 0; g < NUM_GATES; g++) begin
      m_a[g] = 0; m_b[g] = 0; m_c[g] = 0; m_inv[g] = 3'b000;
    end
    m_sel = NUM_IN + NUM_GATES;
  endtask

  // All tasks start and end at a negedge; inputs change only there.
  task automatic cfg_gate(input int g, input int a, input int b, input int c, input logic [2:0] inv);
    cfg_we = 1'b1; cfg_addr = AW'(g); cfg_a = IDX_W'(a); cfg_b = IDX_W'(b); cfg_c = IDX_W'(c);
    cfg_inv = inv;
    @(negedge clk);
    cfg_we = 1'b0;
    m_a[g] = a; m_b[g] = b; m_c[g] = c; m_inv[g] = inv;
  endtask

  task automatic cfg_sel(input int s);
    cfg_out_we = 1'b1; cfg_out = IDX_W'(s);
    @(negedge clk);
    cfg_out_we = 1'b0;
    m_sel = s;
  endtask

  task automatic send(input logic [NUM_IN-1:0] x, output int lat, output logic d, output bit to);
    int n;
    to = 0; lat = 0; d = 1'b0; n = 0;
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    if (!in_ready) begin to = 1; return; end
    in_valid = 1'b1; in_data = x;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin @(negedge clk); lat++; end
    if (!out_valid) to = 1;
    d = out_data;
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    int lat; logic d; bit to;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({in_ready, out_valid, out_data, cfg_err} !== 4'b0000) begin
      errors++; $display("FAIL reset_outputs got %b want 0000", {in_ready, out_valid, out_data, cfg_err});
    end
    rst_n = 1'b1;
    model_reset();
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_rdy_low got %b want 0", in_ready); end
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_rdy_high got %b want 1", in_ready); end
    send(7'h7F, lat, d, to);
    checks++;
    if (to || lat != LAT) begin errors++; $display("FAIL reset_latency got %0d (to=%0d) want %0d", lat, to, LAT); end
    checks++;
    if (d !== 1'b0) begin errors++; $display("FAIL reset_data got %b want 0", d); end
    handshake();
  endtask

  task automatic test_single_gate();
    int lat; logic d; bit to;
    cfg_gate(0, 1, 2, 3, 3'b000);
    cfg_sel(8);
    send(7'b0000011, lat, d, to);
    checks++;
    if (to || d !== 1'b1) begin errors++; $display("FAIL single_11 got %b (to=%0d) want 1", d, to); end
    handshake();
    send(7'b0000001, lat, d, to);
    checks++;
    if (to || d !== 1'b0) begin errors++; $display("FAIL single_01 got %b (to=%0d) want 0", d, to); end
    handshake();
  endtask

  task automatic test_chain();
    int lat; logic d; bit to;
    cfg_gate(0, 3, 5, 6, 3'b000);
    cfg_gate(1, 1, 2, 8, 3'b000);
    cfg_sel(9);
    send(7'b0110011, lat, d, to);
    checks++;
    if (to || d !== 1'b1) begin errors++; $display("FAIL chain_hi got %b (to=%0d) want 1", d, to); end
    handshake();
    send(7'b0000001, lat, d, to);
    checks++;
    if (to || d !== 1'b0) begin errors++; $display("FAIL chain_lo got %b (to=%0d) want 0", d, to); end
    handshake();
  endtask

  task automatic test_backpressure();
    int lat; logic d0, d; bit to;
    send(7'b0110011, lat, d0, to);
    checks++;
    if (to || d0 !== 1'b1) begin errors++; $display("FAIL bp_first got %b (to=%0d) want 1", d0, to); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({out_valid, out_data, in_ready} !== {1'b1, d0, 1'b0}) begin
        errors++; $display("FAIL bp_hold[%0d] got v/d/r %b want %b", i, {out_valid, out_data, in_ready}, {1'b1, d0, 1'b0});
      end
      checks++;
      if (cfg_err !== (i == 2)) begin errors++; $display("FAIL bp_cfg_err[%0d] got %b want %b", i, cfg_err, (i == 2)); end
      cfg_we = (i == 1); cfg_addr = 3'd1; cfg_a = '0; cfg_b = '0; cfg_c = '0; cfg_inv = 3'b000;
      @(negedge clk);
    end
    cfg_we = 1'b0;
    handshake();
    send(7'b0110011, lat, d, to);
    checks++;
    if (to || d !== model_eval(7'b0110011)) begin errors++; $display("FAIL bp_table_kept got %b want %b", d, model_eval(7'b0110011)); end
    handshake();
  endtask

  task automatic test_cfg_with_accept();
    int n; logic exp;
    n = 0;
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    in_valid = 1'b1; in_data = 7'b0000001;
    cfg_we = 1'b1; cfg_addr = 3'd1; cfg_a = 4'd1; cfg_b = 4'd1; cfg_c = 4'd1; cfg_inv = 3'b000;
    m_a[1] = 1; m_b[1] = 1; m_c[1] = 1; m_inv[1] = 3'b000;
    exp = model_eval(7'b0000001);
    @(negedge clk);
    in_valid = 1'b0; cfg_we = 1'b0;
    checks++;
    if (cfg_err !== 1'b0) begin errors++; $display("FAIL same_cycle_err got %b want 0", cfg_err); end
    n = 0;
    while (!out_valid && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (out_valid !== 1'b1 || out_data !== exp || exp !== 1'b1) begin
      errors++; $display("FAIL same_cycle_cfg got %b want 1", out_data);
    end
    handshake();
  endtask

  task automatic test_reset_mid_eval();
    int lat, seen; logic d; bit to;
    int n;
    n = 0;
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    in_valid = 1'b1; in_data = 7'b0110011;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    seen = 0;
    out_ready = 1'b0;
    repeat (15) begin @(negedge clk); if (out_valid !== 1'b0) seen++; end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL abort_no_valid got %0d valid cycles want 0", seen); end
    send(7'b0110011, lat, d, to);
    checks++;
    if (to || d !== 1'b0) begin errors++; $display("FAIL abort_table_cleared got %b (to=%0d) want 0", d, to); end
    handshake();
  endtask

  task automatic test_inv();
    int lat; logic d, exp; bit to;
    logic [NUM_IN-1:0] x;
`ifdef MAJ_INV_EN
    exp = 1'b1;
`else
    exp = 1'b0;
`endif
    cfg_gate(0, 0, 0, 1, 3'b011);
    cfg_sel(8);
    for (int i = 0; i < 4; i++) begin
      x = NUM_IN'($urandom);
      send(x, lat, d, to);
      checks++;
      if (to || d !== exp) begin errors++; $display("FAIL inv[%0d] x=%b got %b want %b", i, x, d, exp); end
      handshake();
    end
  endtask

  task automatic random_table();
    for (int g = 0; g < NUM_GATES; g++)
      cfg_gate(g, $urandom_range(0, NODES - 1), $urandom_range(0, NODES - 1),
               $urandom_range(0, NODES - 1), 3'($urandom));
    cfg_sel($urandom_range(0, NODES - 1));
  endtask

  task automatic test_random();
    int lat; logic d, exp; bit to;
    logic [NUM_IN-1:0] x;
    for (int it = 0; it < 15; it++) begin
      random_table();
      for (int v = 0; v < 3; v++) begin
        x = NUM_IN'($urandom);
        exp = model_eval(x);
        send(x, lat, d, to);
        checks++;
        if (to || lat != LAT) begin errors++; $display("FAIL rand_lat[%0d.%0d] got %0d want %0d", it, v, lat, LAT); end
        checks++;
        if (d !== exp) begin errors++; $display("FAIL rand_data[%0d.%0d] x=%b got %b want %b", it, v, x, d, exp); end
        repeat ($urandom_range(0, 3)) @(negedge clk);
        handshake();
      end
    end
  endtask

  task automatic test_back_to_back();
    logic q[$];
    logic exp;
    int cyc, prev, gaps_bad, naccept;
    bit change;
    random_table();
    prev = -1; gaps_bad = 0; naccept = 0; change = 0;
    out_ready = 1'b1; in_valid = 1'b1; in_data = NUM_IN'($urandom);
    for (cyc = 0; cyc < 80; cyc++) begin
      if (change) begin in_data = NUM_IN'($urandom); change = 0; end
      if (cyc == 60) in_valid = 1'b0;
      if (out_valid) begin
        exp = (q.size() > 0) ? q.pop_front() : 1'bx;
        checks++;
        if (out_data !== exp) begin errors++; $display("FAIL b2b_data cyc %0d got %b want %b", cyc, out_data, exp); end
      end
      if (in_valid && in_ready) begin
        q.push_back(model_eval(in_data));
        if (prev >= 0 && cyc - prev != NUM_GATES + 2) gaps_bad++;
        prev = cyc; naccept++; change = 1;
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
    checks++;
    if (gaps_bad != 0 || naccept < 5) begin
      errors++; $display("FAIL b2b_throughput bad_gaps %0d accepts %0d want 0 and >=5", gaps_bad, naccept);
    end
    checks++;
    if (q.size() != 0) begin errors++; $display("FAIL b2b_drain left %0d want 0", q.size()); end
  endtask

  initial begin
    rst_n = 1'b0; cfg_we = 1'b0; cfg_out_we = 1'b0; cfg_addr = '0; cfg_a = '0; cfg_b = '0;
    cfg_c = '0; cfg_inv = '0; cfg_out = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_single_gate();
    test_chain();
    test_backpressure();
    test_cfg_with_accept();
    test_reset_mid_eval();
    test_inv();
    test_random();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
